counter_sequencer: RTL and testbench

Controller that sequences a loadable up-counter: it drives the counter's `ld`, `cnt` and `D` pins to run a programmed count from a start value to an end value at a programmable pace. It then either finishes with a `done` pulse or auto-reloads and repeats. It sits between the control logic and the up-counter instance, and reads the counter's `Q` back to detect the terminal value.

---
 rtl/counter_sequencer_if.sv | 12 +
 rtl/counter_sequencer.sv | 118 +++++++++++
 tb/tb_counter_sequencer.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/counter_sequencer_if.sv
// rtl/counter_sequencer_if.sv - pin bundle between the sequencer and a loadable up-counter
interface counter_sequencer_if #(
    parameter int WIDTH = 4
);
    logic             ld;
    logic             cnt;
    logic [WIDTH-1:0] d;
    logic [WIDTH-1:0] q;

    modport master (output ld, output cnt, output d, input q);
    modport slave  (input ld, input cnt, input d, output q);
endinterface

// File: rtl/counter_sequencer.sv
// rtl/counter_sequencer.sv - drives a loadable up-counter from a start to an end value at a set pace
module counter_sequencer #(
    parameter int WIDTH  = 4,
    parameter int PACE_W = 4
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_start,
    input  logic [WIDTH-1:0]    i_start_val,
    input  logic [WIDTH-1:0]    i_end_val,
    input  logic [PACE_W-1:0]   i_pace,
    input  logic                i_auto_reload,
    input  logic                i_abort,
    counter_sequencer_if.master cnt_if,
    output logic                o_busy,
    output logic                o_done,
    output logic [7:0]          o_reloads
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [PACE_W-1:0]   r_pc;
    logic [PACE_W-1:0]   w_pc_next;
    logic [WIDTH-1:0]    r_start_val;
    logic [WIDTH-1:0]    r_end_val;
    logic [PACE_W-1:0]   r_pace;
    logic                r_auto_reload;
    logic [7:0]          r_reloads;
    logic                w_accept;
    logic                w_reload_inc;
    logic                w_ld;
    logic                w_cnt;
    logic [WIDTH-1:0]    w_d;

    always_comb begin
        w_next       = r_state;
        w_pc_next    = '0;
        w_accept     = 1'b0;
        w_reload_inc = 1'b0;
        w_ld         = 1'b0;
        w_cnt        = 1'b0;
        w_d          = '0;
        case (r_state)
            S_IDLE: begin
                if (i_start && !i_abort) begin
                    w_accept = 1'b1;
                    w_next   = S_LOAD;
                end
            end
            S_LOAD: begin
                w_ld   = 1'b1;
                w_d    = r_start_val;
                w_next = S_RUN;
            end
            S_RUN: begin
                // Terminal check wins over the prescaler so N=0 passes never pulse cnt.
                if (cnt_if.q == r_end_val) begin
                    w_next       = r_auto_reload ? S_LOAD : S_DONE;
                    w_reload_inc = r_auto_reload;
                end else if (r_pc == r_pace) begin
                    w_cnt = 1'b1;
                end else begin
                    w_pc_next = r_pc + PACE_W'(1);
                end
            end
            S_DONE: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
        if (i_abort && r_state != S_IDLE) begin
            w_next       = S_IDLE;
            w_ld         = 1'b0;
            w_cnt        = 1'b0;
            w_reload_inc = 1'b0;
            w_pc_next    = '0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state       <= S_IDLE;
            r_pc          <= '0;
            r_start_val   <= '0;
            r_end_val     <= '0;
            r_pace        <= '0;
            r_auto_reload <= 1'b0;
            r_reloads     <= 8'd0;
        end else begin
            r_state <= w_next;
            r_pc    <= w_pc_next;
            if (w_accept) begin
                r_start_val   <= i_start_val;
                r_end_val     <= i_end_val;
                r_pace        <= i_pace;
                r_auto_reload <= i_auto_reload;
                r_reloads     <= 8'd0;
            end else if (w_reload_inc && r_reloads != 8'hFF) begin
                r_reloads <= r_reloads + 8'd1;
            end
        end
    end

    assign cnt_if.ld  = w_ld;
    assign cnt_if.cnt = w_cnt;
    assign cnt_if.d   = w_d;
    assign o_busy     = (r_state != S_IDLE);
    assign o_done     = (r_state == S_DONE);
    assign o_reloads  = r_reloads;
endmodule

// File: tb/tb_counter_sequencer.sv
// tb/tb_counter_sequencer.sv - directed table-driven bench for counter_sequencer
module tb_counter_sequencer;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       auto_reload = 1'b0;
    logic       abort = 1'b0;
    logic [3:0] start_val = 4'd0;
    logic [3:0] end_val = 4'd0;
    logic [3:0] pace = 4'd0;
    logic       busy;
    logic       done;
    logic [7:0] reloads;
    logic [3:0] cq;

    always #5 clk = ~clk;

    counter_sequencer_if #(.WIDTH(4)) cif ();

    counter_sequencer #(.WIDTH(4), .PACE_W(4)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_start      (start),
        .i_start_val  (start_val),
        .i_end_val    (end_val),
        .i_pace       (pace),
        .i_auto_reload(auto_reload),
        .i_abort      (abort),
        .cnt_if       (cif),
        .o_busy       (busy),
        .o_done       (done),
        .o_reloads    (reloads)
    );

    // Loadable up-counter being sequenced
    always_ff @(posedge clk) begin
        if (rst)          cq <= 4'd0;
        else if (cif.ld)  cq <= cif.d;
        else if (cif.cnt) cq <= cq + 4'd1;
    end
    assign cif.q = cq;

    typedef struct {
        logic [3:0]  sv;
        logic [3:0]  ev;
        logic [3:0]  pc;
        logic        ar;
        int          n;
        logic [31:0] ld;
        logic [31:0] cnt;
        logic [31:0] dn;
        logic [31:0] bsy;
    } vec_t;

    vec_t        tbl[5];
    int          checks = 0;
    int          failures = 0;
    logic [31:0] m_ld, m_cnt, m_done, m_busy;
    logic [3:0]  d_ld, d_other;
    logic [3:0]  q_tr[64];
    logic [7:0]  rl_tr[1024];
    logic        any_done;
    logic        last_busy;
    int          abort_at = -1;
    int          restart_at = -1;
    int          rst_at = -1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic run_trace(input logic [3:0] sv, input logic [3:0] ev, input logic [3:0] pc,
                             input logic ar, input int n);
        m_ld = '0; m_cnt = '0; m_done = '0; m_busy = '0;
        d_ld = '0; d_other = '0; any_done = 1'b0;
        start_val = sv; end_val = ev; pace = pc; auto_reload = ar;
        start = 1'b1;
        abort = (abort_at == 0);
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            if (c < 32) begin
                m_ld[c]   = cif.ld;
                m_cnt[c]  = cif.cnt;
                m_done[c] = done;
                m_busy[c] = busy;
            end
            if (cif.ld && c == 1) d_ld = cif.d;
            if (!cif.ld) d_other = d_other | cif.d;
            if (done) any_done = 1'b1;
            if (c < 64) q_tr[c] = cq;
            if (c < 1024) rl_tr[c] = reloads;
            last_busy = busy;
            @(posedge clk);
            #1;
            // Scramble the parameter inputs so only latched copies can be in use
            start_val   = ~sv;
            end_val     = ~ev;
            pace        = ~pc;
            auto_reload = ~ar;
            start = (c + 1 == restart_at);
            abort = (c + 1 == abort_at);
            rst   = (c + 1 == rst_at);
        end
        start = 1'b0; abort = 1'b0; rst = 1'b0;
        abort_at = -1; restart_at = -1; rst_at = -1;
    endtask

    task automatic chk_masks(input string tag, input vec_t v);
        chk({tag, "_ld"},   m_ld,   v.ld);
        chk({tag, "_cnt"},  m_cnt,  v.cnt);
        chk({tag, "_done"}, m_done, v.dn);
        chk({tag, "_busy"}, m_busy, v.bsy);
        chk({tag, "_d_load"}, {28'd0, d_ld}, {28'd0, v.sv});
        chk({tag, "_d_idle"}, {28'd0, d_other}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout actual=running expected=finished");
        $fatal(1);
    end

    initial begin
        tbl[0] = '{sv: 4'd3,  ev: 4'd6,  pc: 4'd0, ar: 1'b0, n: 24,
                   ld: 32'h2, cnt: 32'h1C,    dn: 32'h40,    bsy: 32'h7E};
        tbl[1] = '{sv: 4'd5,  ev: 4'd5,  pc: 4'd3, ar: 1'b0, n: 24,
                   ld: 32'h2, cnt: 32'h0,     dn: 32'h8,     bsy: 32'hE};
        tbl[2] = '{sv: 4'd14, ev: 4'd1,  pc: 4'd1, ar: 1'b0, n: 24,
                   ld: 32'h2, cnt: 32'hA8,    dn: 32'h200,   bsy: 32'h3FE};
        tbl[3] = '{sv: 4'd0,  ev: 4'd15, pc: 4'd0, ar: 1'b0, n: 24,
                   ld: 32'h2, cnt: 32'h1FFFC, dn: 32'h40000, bsy: 32'h7FFFE};
        tbl[4] = '{sv: 4'd7,  ev: 4'd9,  pc: 4'd2, ar: 1'b0, n: 24,
                   ld: 32'h2, cnt: 32'h90,    dn: 32'h200,   bsy: 32'h3FE};

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_outputs", {15'd0, busy, done, cif.ld, cif.cnt, cif.d, reloads},
            32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 5; i++) begin
            run_trace(tbl[i].sv, tbl[i].ev, tbl[i].pc, tbl[i].ar, tbl[i].n);
            chk_masks($sformatf("vec%0d", i), tbl[i]);
        end

        // Wrapping pass: observe the counter value after each increment
        run_trace(4'd14, 4'd1, 4'd1, 1'b0, 12);
        chk("wrap_q", {16'd0, q_tr[2], q_tr[4], q_tr[6], q_tr[8]}, 32'hEF01);

        // start while busy is ignored
        restart_at = 3;
        run_trace(4'd3, 4'd6, 4'd0, 1'b0, 24);
        chk_masks("busy_start", tbl[0]);

        // Reset in the middle of RUN
        rst_at = 4;
        run_trace(4'd2, 4'd9, 4'd0, 1'b0, 10);
        chk("rst_busy", m_busy, 32'h1E);
        chk("rst_cnt",  m_cnt,  32'h1C);
        chk("rst_done", m_done, 32'h0);
        chk("rst_after", {20'd0, rl_tr[5], q_tr[5]}, 32'd0);
        run_trace(4'd3, 4'd6, 4'd0, 1'b0, 24);
        chk_masks("post_rst", tbl[0]);

        // Auto-reload with abort in cycle 18
        abort_at = 18;
        run_trace(4'd0, 4'd2, 4'd0, 1'b1, 21);
        chk("ar_ld",   m_ld,   32'h22222);
        chk("ar_cnt",  m_cnt,  32'hCCCC);
        chk("ar_done", m_done, 32'h0);
        chk("ar_busy", m_busy, 32'h7FFFE);
        chk("ar_reloads_18", {24'd0, rl_tr[18]}, 32'd4);
        chk("ar_reloads_hold", {24'd0, rl_tr[20]}, 32'd4);

        // abort together with start in IDLE
        abort_at = 0;
        run_trace(4'd3, 4'd6, 4'd0, 1'b0, 6);
        chk("idle_abort_busy", m_busy, 32'h0);

        // Reload counter saturation
        abort_at = 590;
        run_trace(4'd4, 4'd4, 4'd0, 1'b1, 600);
        chk("sat_mid",  {24'd0, rl_tr[400]}, 32'd199);
        chk("sat_top",  {24'd0, rl_tr[589]}, 32'd255);
        chk("sat_hold", {24'd0, rl_tr[599]}, 32'd255);
        chk("sat_idle", {31'd0, last_busy},  32'd0);
        chk("sat_done", {31'd0, any_done},   32'd0);

        // New start after saturation clears reloads
        run_trace(4'd3, 4'd6, 4'd0, 1'b0, 24);
        chk("restart_reloads", {24'd0, rl_tr[3]}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
